// File: rtl/sram_pkg.sv
// Shared definitions for the operand SRAM: FSM state codes, default geometry and
// the legal read-latency set.
package sram_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_CLEAR = 1'b1;

  localparam int unsigned DEF_A_WIDTH = 15;
  localparam int unsigned DEF_D_WIDTH = 8;

  function automatic bit read_lat_legal(int unsigned lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/sram_sp_array.sv
// Single-port storage: one write port, registered read, no reset on contents so it
// maps onto a RAM macro.
module sram_sp_array #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_operand_clr.sv
// Operand SRAM with a one-word-per-cycle clear engine, busy/done/error flags and a
// read latency of one or two cycles.
module sram_operand_clr
  import sram_pkg::*;
#(
  parameter int unsigned A_WIDTH        = DEF_A_WIDTH,
  parameter int unsigned D_WIDTH        = DEF_D_WIDTH,
  parameter int unsigned READ_LAT       = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Clr,
  input  logic               En,
  input  logic               RW,
  input  logic [A_WIDTH-1:0] Addr,
  input  logic [D_WIDTH-1:0] Data_In,
  output logic [D_WIDTH-1:0] Data_Out,
  output logic               Rd_Valid,
  output logic               Busy,
  output logic               Clr_Done,
  output logic               Err
);

  if (!read_lat_legal(READ_LAT)) begin : g_bad_read_lat
    $error("READ_LAT must be 1 or 2");
  end

  logic               state_q, state_d;
  logic [A_WIDTH-1:0] ptr_q, ptr_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               rd_v1_q;

  logic               mem_we;
  logic               mem_re;
  logic [A_WIDTH-1:0] mem_addr;
  logic [D_WIDTH-1:0] mem_wdata;
  logic [D_WIDTH-1:0] mem_rdata;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = Addr;
    mem_wdata = Data_In;

    case (state_q)
      ST_IDLE: begin
        if (Clr) begin
          // Clear wins over a same-cycle access, which is dropped and flagged.
          state_d = ST_CLEAR;
          ptr_d   = '0;
          err_d   = En;
        end else if (En) begin
          mem_we = RW;
          mem_re = !RW;
        end
      end
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = ptr_q;
        mem_wdata = '0;
        err_d     = En || Clr;
        if (ptr_q == {A_WIDTH{1'b1}}) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!Rst) begin
      mem_we = 1'b0;
      mem_re = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      ptr_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_v1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_v1_q <= mem_re;
    end
  end

  sram_sp_array #(
    .AW (A_WIDTH),
    .DW (D_WIDTH)
  ) u_array (
    .clk_i   (Clk),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  logic               out_v;
  logic [D_WIDTH-1:0] out_d;

  if (READ_LAT == 2) begin : g_lat2
    logic               rd_v2_q;
    logic [D_WIDTH-1:0] rd_d2_q;

    always_ff @(posedge Clk) begin
      if (!Rst) begin
        rd_v2_q <= 1'b0;
        rd_d2_q <= '0;
      end else begin
        rd_v2_q <= rd_v1_q;
        rd_d2_q <= rd_v1_q ? mem_rdata : '0;
      end
    end

    assign out_v = rd_v2_q;
    assign out_d = rd_d2_q;
  end else begin : g_lat1
    assign out_v = rd_v1_q;
    assign out_d = mem_rdata;
  end

  // Array contents are unreset, so gate the data so nothing leaks when idle.
  assign Data_Out = out_v ? out_d : '0;
  assign Rd_Valid = out_v;
  assign Busy     = (state_q == ST_CLEAR);
  assign Clr_Done = done_q;
  assign Err      = err_q;

endmodule

// File: tb/tb_sram_operand_clr.sv
// Drives two instances (read latency 1 and 2) with identical stimulus and checks
// both against a word-level memory model every cycle.
module tb_sram_operand_clr;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int N = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          en  = 1'b0;
  logic          rw  = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] din  = '0;

  logic [DW-1:0] dout1, dout2;
  logic          v1, v2, busy1, busy2, done1, done2, err1, err2;

  always #5 clk = ~clk;

  sram_operand_clr #(.A_WIDTH(AW), .D_WIDTH(DW), .READ_LAT(1), .CLEAR_ON_RESET(1'b1)) u_dut1 (
    .Clk(clk), .Rst(rst), .Clr(clr), .En(en), .RW(rw), .Addr(addr), .Data_In(din),
    .Data_Out(dout1), .Rd_Valid(v1), .Busy(busy1), .Clr_Done(done1), .Err(err1)
  );

  sram_operand_clr #(.A_WIDTH(AW), .D_WIDTH(DW), .READ_LAT(2), .CLEAR_ON_RESET(1'b1)) u_dut2 (
    .Clk(clk), .Rst(rst), .Clr(clr), .En(en), .RW(rw), .Addr(addr), .Data_In(din),
    .Data_Out(dout2), .Rd_Valid(v2), .Busy(busy2), .Clr_Done(done2), .Err(err2)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: plain memory image, clear countdown, and a history of read results per edge.
  int m_mem [N];
  bit m_busy = 1'b0;
  int m_left = 0;
  bit m_done = 1'b0;
  bit m_err  = 1'b0;
  bit hv [2] = '{1'b0, 1'b0};
  int hd [2] = '{0, 0};
  bit nv;
  int nd;
  bit chk_on = 1'b0;

  always @(posedge clk) begin
    nv = 1'b0;
    nd = 0;
    if (!rst) begin
      m_busy = 1'b1;
      m_left = N;
      m_done = 1'b0;
      m_err  = 1'b0;
    end else begin
      m_done = 1'b0;
      m_err  = 1'b0;
      if (m_busy) begin
        m_mem[N - m_left] = 0;
        m_left = m_left - 1;
        m_err  = en || clr;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (clr) begin
        m_busy = 1'b1;
        m_left = N;
        m_err  = en;
      end else if (en) begin
        if (rw) m_mem[addr] = int'(din);
        else begin
          nv = 1'b1;
          nd = m_mem[addr];
        end
      end
    end
    hv[1] = rst ? hv[0] : 1'b0;
    hd[1] = hd[0];
    hv[0] = nv;
    hd[0] = nd;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("busy1", busy1, m_busy);
      check("busy2", busy2, m_busy);
      check("done1", done1, m_done);
      check("done2", done2, m_done);
      check("err1", err1, m_err);
      check("err2", err2, m_err);
      check("rdv1", v1, hv[0]);
      check("dout1", dout1, hv[0] ? hd[0] : 0);
      check("rdv2", v2, hv[1]);
      check("dout2", dout2, hv[1] ? hd[1] : 0);
    end
  end

  task automatic drive(bit r, bit c, bit e, bit w, int a, int d);
    logic [31:0] av, dv;
    av = a;
    dv = d;
    @(negedge clk);
    rst  = r;
    clr  = c;
    en   = e;
    rw   = w;
    addr = av[AW-1:0];
    din  = dv[DW-1:0];
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic count_busy(output int n);
    int g;
    n = 0;
    g = 0;
    while (busy1 && g < 40) begin
      n++;
      g++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy1 && g < 40) begin
      @(negedge clk);
      g++;
    end
    check("wait_idle", busy1, 1'b0);
  endtask

  int nbusy;

  initial begin
    // Two reset edges, then release; Busy must last exactly 16 cycles.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    chk_on = 1'b1;
    idle();
    count_busy(nbusy);
    check("t1_busy_len", nbusy, 16);
    check("t1_done1", done1, 1'b1);
    check("t1_done2", done2, 1'b1);
    for (int a = 0; a < N; a++) drive(1'b1, 1'b0, 1'b1, 1'b0, a, 0);
    idle();
    idle();

    // Write then read back, latency 1 and 2.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3, 8'hA5);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3, 0);
    idle();
    check("t2_lat1_v", v1, 1'b1);
    check("t2_lat1_d", dout1, 8'hA5);
    check("t2_lat2_early", dout2, 8'h00);
    idle();
    check("t2_lat2_d", dout2, 8'hA5);
    check("t2_lat1_after", dout1, 8'h00);

    // Write during a clear is dropped and flagged.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 5, 8'h3C);
    idle();
    check("t3_err", err1, 1'b1);
    wait_idle();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 5, 0);
    idle();
    check("t3_rd_v", v1, 1'b1);
    check("t3_rd_d", dout1, 8'h00);

    // Reset mid-clear restarts a full pass.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 7; i++) idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    idle();
    count_busy(nbusy);
    check("t4_busy_len", nbusy, 16);

    // Clr together with a write: write dropped, Err, clear runs.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 2, 8'h77);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2, 8'h99);
    idle();
    check("t5_err", err1, 1'b1);
    check("t5_busy", busy1, 1'b1);
    wait_idle();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 2, 0);
    idle();
    check("t5_rd_d", dout1, 8'h00);

    // Back-to-back reads through the two-stage pipeline.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1, 8'h11);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 2, 8'h22);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3, 8'h33);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1, 0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 2, 0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3, 0);
    check("t6_lat2_a_v", v2, 1'b1);
    check("t6_lat2_a", dout2, 8'h11);
    idle();
    check("t6_lat2_b", dout2, 8'h22);
    idle();
    check("t6_lat2_c", dout2, 8'h33);
    idle();
    check("t6_lat2_end", v2, 1'b0);

    // Random traffic including occasional clears and resets.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 299) != 0, $urandom_range(0, 59) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, N - 1)), int'($urandom_range(0, 255)));
    end
    idle();
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
